// File: rtl/muldiv_unit.sv
// Radix-2 iterative multiply/divide unit covering the RV32M/RV64M operation set.
// Optional macro MULDIV_FAST_MUL_EN: single-cycle combinational multiplies; divides stay iterative.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   acc_q, acc_d;     // product high half / partial remainder
  logic [XLEN-1:0]   lo_q, lo_d;       // multiplier / dividend shifting into quotient
  logic [XLEN-1:0]   b_q, b_d;         // multiplicand / divisor magnitude
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              is_div, a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag, special_res;
  logic              div_zero, div_ovf, accept;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [XLEN-1:0]   step_acc, step_lo, div_pick;
  logic [2*XLEN-1:0] product, fix_prod;
  logic [XLEN-1:0]   iter_res;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
`endif

  // Operand decode at accept: signedness, magnitudes and the bypass cases.
  always_comb begin
    is_div   = op[2];
    a_signed = is_div ? ~op[0] : (op[1:0] != 2'b11);
    b_signed = is_div ? ~op[0] : ~op[1];
    a_neg    = a_signed & rs1_data[XLEN-1];
    b_neg    = b_signed & rs2_data[XLEN-1];
    a_mag    = a_neg ? -rs1_data : rs1_data;
    b_mag    = b_neg ? -rs2_data : rs2_data;
    div_zero = is_div & (rs2_data == '0);
    div_ovf  = is_div & ~op[0] & (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) & (&rs2_data);
    if (div_zero) special_res = op[1] ? rs1_data : '1;
    else          special_res = op[1] ? '0 : rs1_data;
    accept   = start & ~flush & (state_q != S_BUSY);
`ifdef MULDIV_FAST_MUL_EN
    fast_a    = {{XLEN{a_neg}}, rs1_data};
    fast_b    = {{XLEN{b_neg}}, rs2_data};
    fast_prod = fast_a * fast_b;
`endif
  end

  // One radix-2 step plus the sign fix-up applied to the final step's outcome.
  always_comb begin
    mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_shift = {acc_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, b_q};
    if (op_q[2]) begin
      step_acc = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
      step_lo  = {lo_q[XLEN-2:0], ~div_diff[XLEN]};
    end else begin
      step_acc = mul_sum[XLEN:1];
      step_lo  = {mul_sum[0], lo_q[XLEN-1:1]};
    end
    product  = {step_acc, step_lo};
    fix_prod = neg_q ? -product : product;
    div_pick = op_q[1] ? step_acc : step_lo;
    if (op_q[2])              iter_res = neg_q ? -div_pick : div_pick;
    else if (op_q[1:0] == '0) iter_res = fix_prod[XLEN-1:0];
    else                      iter_res = fix_prod[2*XLEN-1:XLEN];
  end

  // NOTE: every next-state signal takes its hold value first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    b_d      = b_q;
    op_d     = op_q;
    neg_d    = neg_q;
    result_d = result_q;
    case (state_q)
      S_BUSY: begin
        acc_d = step_acc;
        lo_d  = step_lo;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          result_d = iter_res;
          state_d  = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        if (accept) begin
          op_d  = op;
          acc_d = '0;
          lo_d  = a_mag;
          b_d   = b_mag;
          neg_d = (is_div & op[1]) ? a_neg : (a_neg ^ b_neg);
          cnt_d = CNT_W'(XLEN);
          if (div_zero | div_ovf) begin
            result_d = special_res;
            state_d  = S_DONE;
          end else begin
`ifdef MULDIV_FAST_MUL_EN
            if (!is_div) begin
              result_d = (op[1:0] == '0) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
              state_d  = S_DONE;
            end else begin
              state_d  = S_BUSY;
            end
`else
            state_d = S_BUSY;
`endif
          end
        end
      end
    endcase
    if (flush) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      b_q      <= b_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == S_BUSY);
  assign stall  = ((state_q == S_IDLE) & start) | (state_q == S_BUSY);
  assign done   = (state_q == S_DONE) & ~flush;
  assign result = result_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised multi-cycle multiply/divide execution unit covering the full RV32M/RV64M M-extension operation set.
- Sits in the EX stage beside the single-cycle ALU; the control unit enables it when it decodes an M-extension opcode.
- Radix-2 iterative datapath; the result is selected into the EX/MEM result path.
- Drives a stall request that freezes PC, IF/ID and ID/EX while an operation is in flight.

Parameters:
- XLEN, 32, operand and result width (32 or 64).
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived; do not override).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request from ID/EX (enable qualified by valid instruction).
- op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_data  input  XLEN  operand A (post-forwarding).
- rs2_data  input  XLEN  operand B (post-forwarding).
- flush  input  1  abort the in-flight operation (branch taken).
- busy  output  1  unit in BUSY state.
- stall  output  1  pipeline hold request (combinational).
- done  output  1  one-cycle result-valid pulse.
- result  output  XLEN  operation result; held until the next accepted start.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, result=0, all internal registers 0. Reset asserted mid-operation aborts immediately to IDLE with no done.
- States: IDLE, BUSY, DONE.
- IDLE: start=1 latches op and operands, loads counter=XLEN, goes to BUSY.
  - Division-by-zero and signed-overflow operations instead go straight to DONE.
- BUSY: one iteration per cycle, counter decrements. When counter reaches 1, the sign fix-up is applied, result is registered and the state goes to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. start=1 while in DONE is accepted as a new operation and goes to BUSY, so back-to-back operations are supported.
- start while BUSY is ignored.
- Latency: start accepted at cycle 0 gives done=1 in cycle XLEN+1. Special cases give done=1 in cycle 1.
- stall = (state==IDLE & start) | (state==BUSY). stall=0 in DONE, so the pipeline advances on the same edge that result is consumed.
- Signed handling:
  - Operands are converted to magnitudes at accept. MULHSU treats rs1 as signed and rs2 as unsigned.
  - Quotient sign = sign(A) xor sign(B); remainder sign = sign(A).
  - Negation (two's complement) is applied once in the final BUSY cycle.
- Multiply:
  - 2*XLEN product register, shift-add, LSB of the multiplier examined each cycle.
  - MUL returns product[XLEN-1:0]; MULH/MULHSU/MULHU return product[2*XLEN-1:XLEN].
- Divide:
  - Restoring shift-subtract, XLEN+1-bit partial remainder.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- Boundary cases:
  - Divide by zero: quotient = all ones; remainder = rs1_data.
  - Signed overflow (rs1 = -2^(XLEN-1), rs2 = -1, DIV/REM): quotient = rs1_data, remainder = 0.
  - Both cases bypass iteration.
- flush=1 in any state: next state IDLE, done not asserted, result unchanged. flush and start in the same cycle: flush wins and the start is dropped.
- Operands are sampled only at accept; changes on rs1_data/rs2_data during BUSY have no effect.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined: MUL/MULH/MULHSU/MULHU use a combinational XLEN x XLEN signed-extended multiplier. The accepting edge goes IDLE to DONE, giving done in cycle 1 and stall=1 for one cycle only. Divide operations remain iterative.
- Undefined: all multiplies are iterative with XLEN+1 cycle latency, and no hardware multiplier is inferred.

Test Plan:
- XLEN=32, MUL 7 x -3 (rs2=0xFFFFFFFD) -> done in cycle 33, result=0xFFFFFFEB; stall high cycles 0-32.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result=0xFFFFFFFE. MULH with the same operands -> result=0x00000000. MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, both in cycle 1. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 in cycle 1.
- Start DIVU, assert flush in cycle 10 -> IDLE, no done pulse, result keeps the prior value. Restart immediately -> correct result in cycle XLEN+1 after the restart. Separately: reset asserted in cycle 5 -> all outputs 0 asynchronously.
- Back-to-back: start held high through DONE -> second operation accepted on the DONE edge, two done pulses spaced 33 cycles apart. With MULDIV_FAST_MUL_EN defined, MUL 3x4 -> result 12 in cycle 1.
